// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 frame receiver
//
// Purpose : receiver FSM state encoding, frame geometry constants and the
//           parity-mismatch helper used by ps2_rx.
// Ports   : none (package)
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   localparam int FRAME_BITS = 11;
   localparam int DATA_BITS  = 8;

   // True when the XOR of the data byte and the parity bit does not match
   // the wanted polarity (1 for odd parity, 0 for even parity).
   function automatic logic parity_bad(input logic [DATA_BITS-1:0] d,
                                       input logic                 p,
                                       input logic                 odd);
      return (^{d, p}) != odd;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 11-bit frame receiver sampled on CLKOUT falling edges
//
// Purpose : receives start(0), 8 data bits LSB-first, parity, stop(1) and
//           presents the decoded byte with one-cycle status pulses.
// Config  : PS2_PARITY_CHECK_EN - when defined, the parity bit is checked
//           against ODD_PARITY and drives parity_err; otherwise the parity
//           bit is sampled and ignored and parity_err stays 0.
// Params  : ODD_PARITY  1 = odd parity, 0 = even parity
// Ports   : CLKOUT      in   PS/2 clock, all state changes on its falling edge
//           reset       in   synchronous active-high reset
//           Rx          in   PS/2 data line, idle high
//           data        out  last received byte, held until next good frame
//           data_valid  out  one-cycle pulse, data just updated
//           parity_err  out  one-cycle pulse with data_valid on parity mismatch
//           frame_err   out  one-cycle pulse when the stop bit was 0
//           busy        out  high while a frame is in progress
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int ODD_PARITY = 1
) (
   input  logic                 CLKOUT,
   input  logic                 reset,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

`ifdef PS2_PARITY_CHECK_EN
   localparam logic PARITY_CHECK = 1'b1;
`else
   localparam logic PARITY_CHECK = 1'b0;
`endif

   localparam logic ODD_SEL = (ODD_PARITY != 0);

   state_t               state;
   state_t               state_nx;
   logic [2:0]           cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 par_mismatch;

   logic [DATA_BITS-1:0] data_nx;
   logic                 valid_nx;
   logic                 perr_nx;
   logic                 ferr_nx;

   // With checking disabled the gate forces the mismatch to 0 regardless of
   // the sampled parity bit.
   assign par_mismatch = PARITY_CHECK & parity_bad(shreg, par_bit, ODD_SEL);

   // busy follows the state register directly, so it is glitch-free and
   // drops on the same edge that returns the FSM to IDLE.
   assign busy = (state != IDLE);

   // State register, datapath and registered outputs.
   always_ff @(negedge CLKOUT) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 3'd0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         data       <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nx;
         data       <= data_nx;
         data_valid <= valid_nx;
         parity_err <= perr_nx;
         frame_err  <= ferr_nx;
         case (state)
            IDLE: begin
               cnt <= 3'd0;
            end
            DATA: begin
               shreg[cnt] <= Rx;
               cnt        <= cnt + 3'd1;
            end
            PARITY: begin
               par_bit <= Rx;
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!Rx) state_nx = DATA;
         DATA:    if (cnt == 3'd7) state_nx = PARITY;
         PARITY:  state_nx = STOP;
         STOP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output logic: values registered on the edge that samples the stop bit.
   // A bad stop bit suppresses data_valid entirely, so frame_err and
   // data_valid can never pulse together.
   always_comb begin
      data_nx  = data;
      valid_nx = 1'b0;
      perr_nx  = 1'b0;
      ferr_nx  = 1'b0;
      if (state == STOP) begin
         if (Rx) begin
            data_nx  = shreg;
            valid_nx = 1'b1;
            perr_nx  = par_mismatch;
         end else begin
            ferr_nx  = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - directed self-checking bench for ps2_rx
module tb_ps2_rx;

`ifdef PS2_PARITY_CHECK_EN
   localparam logic PCHK = 1'b1;
`else
   localparam logic PCHK = 1'b0;
`endif

   logic       CLKOUT;
   logic       reset;
   logic       Rx;
   logic [7:0] data;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;
   logic [7:0] data_e;
   logic       data_valid_e;
   logic       parity_err_e;
   logic       frame_err_e;
   logic       busy_e;

   int n_checks = 0;
   int n_errors = 0;

   ps2_rx #(.ODD_PARITY(1)) dut (
      .CLKOUT(CLKOUT), .reset(reset), .Rx(Rx),
      .data(data), .data_valid(data_valid), .parity_err(parity_err),
      .frame_err(frame_err), .busy(busy)
   );

   ps2_rx #(.ODD_PARITY(0)) dut_e (
      .CLKOUT(CLKOUT), .reset(reset), .Rx(Rx),
      .data(data_e), .data_valid(data_valid_e), .parity_err(parity_err_e),
      .frame_err(frame_err_e), .busy(busy_e)
   );

   initial CLKOUT = 1'b1;
   always #1 CLKOUT = ~CLKOUT;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered at a rising edge; drives one bit per rising edge and returns
   // on the rising edge after the stop bit was sampled.
   task automatic frame(input logic [7:0] d, input logic p, input logic stop);
      logic [10:0] f;
      f = {stop, p, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         Rx = f[i];
         @(posedge CLKOUT);
         if (i == 1) chk("busy_in_frame", busy, 1);
         if (i == 9) chk("no_early_valid", data_valid, 0);
      end
   endtask

   task automatic idle(input int n);
      Rx = 1'b1;
      repeat (n) @(posedge CLKOUT);
   endtask

   initial begin
      reset = 1'b1;
      Rx    = 1'b1;
      repeat (2) @(posedge CLKOUT);
      chk("rst_data", data, 8'h00);
      chk("rst_valid", data_valid, 0);
      chk("rst_perr", parity_err, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      idle(1);

      // start,00011100,p=1,stop -> 0x38, 3 ones + p = even count
      frame(8'h38, 1'b1, 1'b1);
      chk("f2_data", data, 8'h38);
      chk("f2_valid", data_valid, 1);
      chk("f2_perr_odd", parity_err, PCHK);
      chk("f2_ferr", frame_err, 0);
      chk("f2_busy", busy, 0);
      chk("f2_perr_even", parity_err_e, 0);
      chk("f2_valid_even", data_valid_e, 1);
      idle(1);
      chk("f2_valid_pulse", data_valid, 0);
      chk("f2_perr_pulse", parity_err, 0);
      idle(4);

      // start,00110010,p=1,stop -> 0x4C, 3 ones + p = even count
      frame(8'h4C, 1'b1, 1'b1);
      chk("f3_data", data, 8'h4C);
      chk("f3_valid", data_valid, 1);
      chk("f3_perr_odd", parity_err, PCHK);
      idle(1);
      chk("f3_valid_pulse", data_valid, 0);

      // 0xA5 with stop bit 0
      frame(8'hA5, 1'b1, 1'b0);
      chk("f4_ferr", frame_err, 1);
      chk("f4_valid", data_valid, 0);
      chk("f4_data_held", data, 8'h4C);
      chk("f4_perr", parity_err, 0);
      idle(1);
      chk("f4_ferr_pulse", frame_err, 0);

      // reset after start + 4 data bits
      Rx = 1'b0;
      @(posedge CLKOUT);
      for (int i = 0; i < 4; i++) begin
         Rx = 1'b1;
         @(posedge CLKOUT);
      end
      chk("f5_busy_pre", busy, 1);
      reset = 1'b1;
      Rx    = 1'b1;
      @(posedge CLKOUT);
      chk("f5_busy_rst", busy, 0);
      chk("f5_data_rst", data, 8'h00);
      chk("f5_valid_rst", data_valid, 0);
      reset = 1'b0;
      idle(2);

      // 0x12, 2 ones + p = odd count; then back-to-back 0x81
      frame(8'h12, 1'b1, 1'b1);
      chk("f5_data", data, 8'h12);
      chk("f5_valid", data_valid, 1);
      chk("f5_perr_odd", parity_err, 0);
      chk("f5_perr_even", parity_err_e, PCHK);
      frame(8'h81, 1'b1, 1'b1);
      chk("b2b_data", data, 8'h81);
      chk("b2b_valid", data_valid, 1);
      chk("b2b_perr_odd", parity_err, 0);
      chk("b2b_perr_even", parity_err_e, PCHK);
      chk("b2b_data_even", data_e, 8'h81);
      idle(1);
      chk("b2b_valid_pulse", data_valid, 0);
      chk("b2b_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
